// File: rtl/vx_mem_credit_arb_pkg.sv
// Shared sizing helpers for the credited memory arbiter.
package vx_mem_credit_arb_pkg;

    // Index bits needed to name one requestor; zero when there is only one.
    function automatic int calc_log_reqs(input int num_reqs);
        return (num_reqs > 32'sd1) ? $clog2(num_reqs) : 32'sd0;
    endfunction

    // Counter width able to hold 0..max_pending inclusive.
    function automatic int calc_cnt_w(input int max_pending);
        return $clog2(max_pending + 32'sd1);
    endfunction

    // Outgoing tag width once the requestor index has been inserted.
    function automatic int calc_tag_out_w(input int tag_in_w, input int num_reqs);
        return tag_in_w + calc_log_reqs(num_reqs);
    endfunction

endpackage

// File: rtl/vx_mem_credit_arb_pending_counter.sv
// Per-requestor outstanding-request counter: saturating up/down with full/empty flags.
module vx_mem_credit_arb_pending_counter #(
    parameter int CNT_W   = 3,
    parameter int MAX_VAL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] count_r;

    // Count credits; a simultaneous inc and dec cancel, and the ends never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && !dec && !full) begin
            count_r <= count_r + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign full  = (count_r == CNT_W'(MAX_VAL));
    assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/vx_mem_credit_arb.sv
// N:1 round-robin request arbiter and 1:N response router with per-requestor credit limits.
module vx_mem_credit_arb
    import vx_mem_credit_arb_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int TAG_IN_WIDTH = 8,
    parameter int TAG_SEL_IDX  = 0,
    parameter int MAX_PENDING  = 4,
    parameter int WRITE_RSP    = 0,
    localparam int DATA_SIZE     = DATA_WIDTH / 8,
    localparam int LOG_NUM_REQS  = calc_log_reqs(NUM_REQS),
    localparam int TAG_OUT_WIDTH = calc_tag_out_w(TAG_IN_WIDTH, NUM_REQS),
    localparam int CNT_W         = calc_cnt_w(MAX_PENDING)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]  req_tag_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_REQS-1:0]               req_rw_in,
    input  logic [NUM_REQS*DATA_SIZE-1:0]     req_byteen_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]    req_data_in,
    output logic [NUM_REQS-1:0]               req_ready_in,
    output logic                              req_valid_out,
    output logic [TAG_OUT_WIDTH-1:0]          req_tag_out,
    output logic [ADDR_WIDTH-1:0]             req_addr_out,
    output logic                              req_rw_out,
    output logic [DATA_SIZE-1:0]              req_byteen_out,
    output logic [DATA_WIDTH-1:0]             req_data_out,
    input  logic                              req_ready_out,
    input  logic                              rsp_valid_in,
    input  logic [TAG_OUT_WIDTH-1:0]          rsp_tag_in,
    input  logic [DATA_WIDTH-1:0]             rsp_data_in,
    output logic                              rsp_ready_in,
    output logic [NUM_REQS-1:0]               rsp_valid_out,
    output logic [NUM_REQS*TAG_IN_WIDTH-1:0]  rsp_tag_out,
    output logic [NUM_REQS*DATA_WIDTH-1:0]    rsp_data_out,
    input  logic [NUM_REQS-1:0]               rsp_ready_out,
    output logic [NUM_REQS*CNT_W-1:0]         pending_out,
    output logic                              rsp_err_out
);

    localparam int SEL_W = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;

    typedef struct packed {
        logic [TAG_OUT_WIDTH-1:0] tag;
        logic [ADDR_WIDTH-1:0]    addr;
        logic                     rw;
        logic [DATA_SIZE-1:0]     byteen;
        logic [DATA_WIDTH-1:0]    data;
    } req_payload_t;

    logic [NUM_REQS-1:0]     credit_needed_s, eligible_s, grant_s;
    logic [NUM_REQS-1:0]     inc_s, dec_s, full_s, empty_s, match_s;
    logic [SEL_W-1:0]        grant_idx_s, rr_ptr_r;
    logic                    any_eligible_s, load_en_s, accept_s;
    logic [TAG_IN_WIDTH-1:0] sel_tag_s;
    logic [TAG_OUT_WIDTH-1:0] ins_tag_s;
    req_payload_t            sel_payload_s, req_pl_r;
    logic                    req_valid_r;

    logic [SEL_W-1:0]        rsp_sel_s, rsp_sel_r;
    logic [TAG_IN_WIDTH-1:0] rsp_tag_strip_s, rsp_tag_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic [NUM_REQS-1:0]     rsp_valid_r;
    logic                    rsp_load_en_s, rsp_fire_s, rsp_known_s, rsp_err_r;

    // ---------------- request path ----------------

    // Eligibility: a credited request may only go when its requestor has room.
    always_comb begin
        credit_needed_s = '0;
        eligible_s      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            credit_needed_s[i] = !req_rw_in[i] || (WRITE_RSP != 0);
            eligible_s[i]      = req_valid_in[i] && (!credit_needed_s[i] || !full_s[i]);
        end
    end

    // Round-robin search over eligible requestors starting at the pointer.
    always_comb begin
        int   idx_v;
        logic found_v;
        logic take_v;
        grant_s     = '0;
        grant_idx_s = '0;
        found_v     = 1'b0;
        take_v      = 1'b0;
        idx_v       = 0;
        for (int off = 0; off < NUM_REQS; off++) begin
            idx_v          = (int'(rr_ptr_r) + off) % NUM_REQS;
            take_v         = !found_v && eligible_s[idx_v];
            grant_s[idx_v] = take_v;
            grant_idx_s    = take_v ? SEL_W'(idx_v) : grant_idx_s;
            found_v        = found_v | take_v;
        end
    end

    assign any_eligible_s = |eligible_s;
    assign load_en_s      = !req_valid_r || req_ready_out;
    assign accept_s       = load_en_s && any_eligible_s;
    assign req_ready_in   = grant_s & {NUM_REQS{load_en_s}};
    assign inc_s          = grant_s & credit_needed_s & {NUM_REQS{accept_s}};
    assign sel_tag_s      = req_tag_in[int'(grant_idx_s)*TAG_IN_WIDTH +: TAG_IN_WIDTH];

    // Insert the requestor index into the outgoing tag at TAG_SEL_IDX.
    for (genvar b = 0; b < TAG_OUT_WIDTH; b++) begin : g_tag_ins
        if (b < TAG_SEL_IDX) begin : g_low
            assign ins_tag_s[b] = sel_tag_s[b];
        end else if (b < TAG_SEL_IDX + LOG_NUM_REQS) begin : g_idx
            assign ins_tag_s[b] = grant_idx_s[b-TAG_SEL_IDX];
        end else begin : g_high
            assign ins_tag_s[b] = sel_tag_s[b-LOG_NUM_REQS];
        end
    end

    // Gather the granted requestor's fields into one payload.
    always_comb begin
        sel_payload_s        = '0;
        sel_payload_s.tag    = ins_tag_s;
        sel_payload_s.addr   = req_addr_in[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_payload_s.rw     = req_rw_in[grant_idx_s];
        sel_payload_s.byteen = req_byteen_in[int'(grant_idx_s)*DATA_SIZE +: DATA_SIZE];
        sel_payload_s.data   = req_data_in[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Request valid and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_r <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            if (load_en_s) begin
                req_valid_r <= any_eligible_s;
            end else begin
                req_valid_r <= req_valid_r;
            end
            if (accept_s) begin
                rr_ptr_r <= (grant_idx_s == SEL_W'(NUM_REQS - 1)) ? SEL_W'(0)
                                                                  : grant_idx_s + SEL_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Request payload register; holds steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            req_pl_r <= sel_payload_s;
        end else begin
            req_pl_r <= req_pl_r;
        end
    end

    assign req_valid_out  = req_valid_r;
    assign req_tag_out    = req_pl_r.tag;
    assign req_addr_out   = req_pl_r.addr;
    assign req_rw_out     = req_pl_r.rw;
    assign req_byteen_out = req_pl_r.byteen;
    assign req_data_out   = req_pl_r.data;

    // ---------------- response path ----------------

    if (LOG_NUM_REQS > 0) begin : g_rsp_sel
        assign rsp_sel_s = rsp_tag_in[TAG_SEL_IDX +: LOG_NUM_REQS];
    end else begin : g_rsp_sel_one
        assign rsp_sel_s = '0;
    end

    // Drop the index bits from the response tag; higher bits move down.
    for (genvar b = 0; b < TAG_IN_WIDTH; b++) begin : g_tag_rm
        if (b < TAG_SEL_IDX) begin : g_low
            assign rsp_tag_strip_s[b] = rsp_tag_in[b];
        end else begin : g_high
            assign rsp_tag_strip_s[b] = rsp_tag_in[b+LOG_NUM_REQS];
        end
    end

    // Decode the target lane; out-of-range indices match no lane.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            match_s[i] = (rsp_sel_s == SEL_W'(i));
        end
    end

    assign rsp_known_s   = |(match_s & ~empty_s);
    assign rsp_load_en_s = !(|rsp_valid_r) || rsp_ready_out[rsp_sel_r];
    assign rsp_fire_s    = rsp_valid_in && rsp_load_en_s;
    assign dec_s         = match_s & ~empty_s & {NUM_REQS{rsp_fire_s}};
    assign rsp_ready_in  = rsp_load_en_s;

    // Response valid and sticky misroute flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (rsp_load_en_s) begin
                rsp_valid_r <= dec_s;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
            rsp_err_r <= rsp_err_r || (rsp_fire_s && !rsp_known_s);
        end
    end

    // Response payload register.
    always_ff @(posedge clk) begin
        if (rsp_fire_s && rsp_known_s) begin
            rsp_sel_r  <= rsp_sel_s;
            rsp_tag_r  <= rsp_tag_strip_s;
            rsp_data_r <= rsp_data_in;
        end else begin
            rsp_sel_r  <= rsp_sel_r;
            rsp_tag_r  <= rsp_tag_r;
            rsp_data_r <= rsp_data_r;
        end
    end

    assign rsp_valid_out = rsp_valid_r;
    assign rsp_tag_out   = {NUM_REQS{rsp_tag_r}};
    assign rsp_data_out  = {NUM_REQS{rsp_data_r}};
    assign rsp_err_out   = rsp_err_r;

    // ---------------- credits ----------------

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_cnt
        vx_mem_credit_arb_pending_counter #(
            .CNT_W   (CNT_W),
            .MAX_VAL (MAX_PENDING)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_s[i]),
            .dec   (dec_s[i]),
            .count (pending_out[i*CNT_W +: CNT_W]),
            .full  (full_s[i]),
            .empty (empty_s[i])
        );
    end

endmodule

// File: tb/tb_vx_mem_credit_arb.sv
// Scoreboard bench for vx_mem_credit_arb with default parameters.
module tb_vx_mem_credit_arb;

    localparam int N    = 4;
    localparam int TW   = 8;
    localparam int TOW  = 10;
    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam int DS   = 8;
    localparam int CW   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid_in;
    logic [N*TW-1:0]   req_tag_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N-1:0]      req_rw_in;
    logic [N*DS-1:0]   req_byteen_in;
    logic [N*DW-1:0]   req_data_in;
    logic [N-1:0]      req_ready_in;
    logic              req_valid_out;
    logic [TOW-1:0]    req_tag_out;
    logic [AW-1:0]     req_addr_out;
    logic              req_rw_out;
    logic [DS-1:0]     req_byteen_out;
    logic [DW-1:0]     req_data_out;
    logic              req_ready_out;
    logic              rsp_valid_in;
    logic [TOW-1:0]    rsp_tag_in;
    logic [DW-1:0]     rsp_data_in;
    logic              rsp_ready_in;
    logic [N-1:0]      rsp_valid_out;
    logic [N*TW-1:0]   rsp_tag_out;
    logic [N*DW-1:0]   rsp_data_out;
    logic [N-1:0]      rsp_ready_out;
    logic [N*CW-1:0]   pending_out;
    logic              rsp_err_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [127:0] exp_req_q[$];
    logic [127:0] exp_rsp_q[$];

    vx_mem_credit_arb dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_tag_in(req_tag_in), .req_addr_in(req_addr_in),
        .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in), .req_data_in(req_data_in),
        .req_ready_in(req_ready_in), .req_valid_out(req_valid_out), .req_tag_out(req_tag_out),
        .req_addr_out(req_addr_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
        .req_data_out(req_data_out), .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_data_in(rsp_data_in),
        .rsp_ready_in(rsp_ready_in), .rsp_valid_out(rsp_valid_out), .rsp_tag_out(rsp_tag_out),
        .rsp_data_out(rsp_data_out), .rsp_ready_out(rsp_ready_out),
        .pending_out(pending_out), .rsp_err_out(rsp_err_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DS-1:0] mk_byteen(input logic [AW-1:0] addr);
        return addr[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] addr);
        return {addr, ~addr};
    endfunction

    function automatic logic [127:0] exp_req(input int i, input logic [TW-1:0] tag,
                                             input logic [AW-1:0] addr, input logic rw);
        logic [1:0] idx;
        idx = 2'(i);
        return {13'd0, tag, idx, addr, rw, mk_byteen(addr), mk_data(addr)};
    endfunction

    function automatic logic [127:0] exp_rsp(input int lane, input logic [TW-1:0] tag,
                                             input logic [DW-1:0] data);
        return {48'd0, 8'(lane), tag, data};
    endfunction

    task automatic drive_req(input int i, input logic v, input logic [TW-1:0] tag,
                             input logic [AW-1:0] addr, input logic rw);
        req_valid_in[i]          = v;
        req_tag_in[i*TW +: TW]   = tag;
        req_addr_in[i*AW +: AW]  = addr;
        req_rw_in[i]             = rw;
        req_byteen_in[i*DS +: DS] = mk_byteen(addr);
        req_data_in[i*DW +: DW]  = mk_data(addr);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid_in = '0; req_tag_in = '0; req_addr_in = '0; req_rw_in = '0;
        req_byteen_in = '0; req_data_in = '0;
        rsp_valid_in = 1'b0; rsp_tag_in = '0; rsp_data_in = '0;
        req_ready_out = 1'b1; rsp_ready_out = '1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [CW-1:0] pend(input int i);
        return pending_out[i*CW +: CW];
    endfunction

    // Monitor: compare every handshaken output against the scoreboard.
    always @(negedge clk) begin
        if (!reset && req_valid_out && req_ready_out) begin
            if (exp_req_q.size() == 0) check_val("req_unexpected", 128'd1, 128'd0);
            else check_val("req_out", {13'd0, req_tag_out, req_addr_out, req_rw_out,
                                       req_byteen_out, req_data_out}, exp_req_q.pop_front());
        end
        for (int l = 0; l < N; l++) begin
            if (!reset && rsp_valid_out[l] && rsp_ready_out[l]) begin
                if (exp_rsp_q.size() == 0) check_val("rsp_unexpected", 128'd1, 128'd0);
                else check_val("rsp_out", {48'd0, 8'(l), rsp_tag_out[l*TW +: TW],
                                           rsp_data_out[l*DW +: DW]}, exp_rsp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check_val("rst_req_valid", 128'(req_valid_out), 128'd0);
        check_val("rst_rsp_valid", 128'(rsp_valid_out), 128'd0);
        check_val("rst_pending", 128'(pending_out), 128'd0);
        check_val("rst_err", 128'(rsp_err_out), 128'd0);
        next_cycle();

        // Round robin: all four valid, grants 0,1,2,3,0 back to back
        for (int i = 0; i < N; i++) drive_req(i, 1'b1, 8'(8'h10 + i), 32'h1000 + 32'(i), 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("rr_grant", 128'(req_ready_in), 128'(4'b0001 << (c % 4)));
            exp_req_q.push_back(exp_req(c % 4, 8'(8'h10 + (c % 4)), 32'h1000 + 32'(c % 4), 1'b0));
            next_cycle();
        end
        req_valid_in = '0;
        next_cycle();
        next_cycle();
        check_val("rr_drained", 128'(exp_req_q.size()), 128'd0);

        // Single read from requestor 2, then its response
        do_reset();
        drive_req(2, 1'b1, 8'h5A, 32'hA000_0002, 1'b0);
        @(negedge clk);
        check_val("single_ready", 128'(req_ready_in), 128'(4'b0100));
        exp_req_q.push_back(exp_req(2, 8'h5A, 32'hA000_0002, 1'b0));
        next_cycle();
        req_valid_in = '0;
        @(negedge clk);
        check_val("single_tag", 128'(req_tag_out), 128'h16A);
        check_val("single_pend", 128'(pend(2)), 128'd1);
        next_cycle();
        rsp_valid_in = 1'b1; rsp_tag_in = {8'h5A, 2'd2}; rsp_data_in = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        check_val("rsp_ready", 128'(rsp_ready_in), 128'd1);
        exp_rsp_q.push_back(exp_rsp(2, 8'h5A, 64'hDEAD_BEEF_0123_4567));
        next_cycle();
        rsp_valid_in = 1'b0;
        @(negedge clk);
        check_val("rsp_onehot", 128'(rsp_valid_out), 128'(4'b0100));
        check_val("rsp_pend", 128'(pend(2)), 128'd0);
        next_cycle();

        // Credit limit on requestor 1
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_req(1, 1'b1, 8'(k), 32'h2000 + 32'(k), 1'b0);
            @(negedge clk);
            check_val("credit_ready", 128'(req_ready_in[1]), 128'd1);
            exp_req_q.push_back(exp_req(1, 8'(k), 32'h2000 + 32'(k), 1'b0));
            next_cycle();
        end
        drive_req(1, 1'b1, 8'd4, 32'h2004, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("credit_stall", 128'(req_ready_in[1]), 128'd0);
            next_cycle();
        end
        @(negedge clk);
        check_val("credit_full", 128'(pend(1)), 128'd4);
        next_cycle();
        rsp_valid_in = 1'b1; rsp_tag_in = {8'hC1, 2'd1}; rsp_data_in = 64'h1111_2222_3333_4444;
        @(negedge clk);
        check_val("credit_no_bypass", 128'(req_ready_in[1]), 128'd0);
        exp_rsp_q.push_back(exp_rsp(1, 8'hC1, 64'h1111_2222_3333_4444));
        next_cycle();
        rsp_valid_in = 1'b0;
        @(negedge clk);
        check_val("credit_pend3", 128'(pend(1)), 128'd3);
        check_val("credit_resume", 128'(req_ready_in[1]), 128'd1);
        exp_req_q.push_back(exp_req(1, 8'd4, 32'h2004, 1'b0));
        next_cycle();
        req_valid_in = '0;
        @(negedge clk);
        check_val("credit_pend4", 128'(pend(1)), 128'd4);
        next_cycle();

        // Writes consume no credit
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive_req(0, 1'b1, 8'(8'h70 + k), 32'h3000 + 32'(k), 1'b1);
            @(negedge clk);
            check_val("write_ready", 128'(req_ready_in[0]), 128'd1);
            exp_req_q.push_back(exp_req(0, 8'(8'h70 + k), 32'h3000 + 32'(k), 1'b1));
            next_cycle();
        end
        req_valid_in = '0;
        @(negedge clk);
        check_val("write_pend", 128'(pend(0)), 128'd0);
        next_cycle();

        // Misrouted response to requestor 3
        rsp_valid_in = 1'b1; rsp_tag_in = {8'h77, 2'd3}; rsp_data_in = 64'h5555;
        @(negedge clk);
        check_val("err_pre", 128'(rsp_err_out), 128'd0);
        check_val("err_ready", 128'(rsp_ready_in), 128'd1);
        next_cycle();
        rsp_valid_in = 1'b0;
        @(negedge clk);
        check_val("err_no_fwd", 128'(rsp_valid_out), 128'd0);
        check_val("err_set", 128'(rsp_err_out), 128'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("err_sticky", 128'(rsp_err_out), 128'd1);
        next_cycle();

        // Reset with both registers loaded and stalled
        req_ready_out = 1'b0; rsp_ready_out = '0;
        drive_req(0, 1'b1, 8'h33, 32'h4000, 1'b0);
        next_cycle();
        req_valid_in = '0;
        rsp_valid_in = 1'b1; rsp_tag_in = {8'h44, 2'd0}; rsp_data_in = 64'h9999;
        next_cycle();
        rsp_valid_in = 1'b0;
        next_cycle();
        @(negedge clk);
        check_val("stall_req_valid", 128'(req_valid_out), 128'd1);
        check_val("stall_req_tag", 128'(req_tag_out), 128'h0CC);
        check_val("stall_rsp_valid", 128'(rsp_valid_out), 128'(4'b0001));
        check_val("stall_rsp_ready", 128'(rsp_ready_in), 128'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_val("mid_rst_req_valid", 128'(req_valid_out), 128'd0);
        check_val("mid_rst_rsp_valid", 128'(rsp_valid_out), 128'd0);
        check_val("mid_rst_pending", 128'(pending_out), 128'd0);
        check_val("mid_rst_err", 128'(rsp_err_out), 128'd0);

        check_val("req_q_empty", 128'(exp_req_q.size()), 128'd0);
        check_val("rsp_q_empty", 128'(exp_rsp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
